// File: rtl/array_seq_pkg.sv
// Shared types and constants for the left-array row sequencer.
// Holds the command opcode encoding, the FSM state type and a small
// helper used to size the setup/pulse timer.
package array_seq_pkg;

  // Command opcodes as they arrive on cmd_op
  localparam logic [1:0] OP_ROW_ENC   = 2'b00;
  localparam logic [1:0] OP_INFER_ENC = 2'b01;
  localparam logic [1:0] OP_CLEAR_ENC = 2'b10;
  localparam logic [1:0] OP_RSVD_ENC  = 2'b11;

  typedef enum logic [1:0] {
    OP_ROW   = OP_ROW_ENC,
    OP_INFER = OP_INFER_ENC,
    OP_CLEAR = OP_CLEAR_ENC,
    OP_RSVD  = OP_RSVD_ENC
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Larger of two integers, used for timer width sizing
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/array_seq_timer.sv
// Loadable down-counter for the SETUP and PULSE phase durations.
// Loading value L makes zero assert after L further cycles, so a phase
// of C cycles is obtained by loading C-1 on the edge that enters it.
module array_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins, otherwise count down and stick at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/array_row_sequencer.sv
// Command-driven sequencer for the left array decoder of the Bayesian
// log2 8x8 macro. Drives CWL, adr_full_row, read_out and inference with
// programmable setup/pulse timing; INFER sweeps every word address.
// Optional feature: define ARRAY_SEQ_ABORT_EN to add the abort input,
// which cuts a running ROW/INFER short and reports err with done.
module array_row_sequencer
  import array_seq_pkg::*;
#(
  parameter int Narray    = 2,
  parameter int Nword     = 3,
  parameter int N         = Nword + Narray,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_adr,
`ifdef ARRAY_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         CWL,
  output logic [N-1:0] adr_full_row,
  output logic         read_out,
  output logic         inference
);

  localparam int TMR_MAX = max2(SETUP_CYC, PULSE_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYC - 1);
  localparam logic [Nword-1:0] WORD_LAST  = {Nword{1'b1}};

  // Control state
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [N-1:0]     row_q, row_d;
  logic [Nword-1:0] widx_q, widx_d;

  // Registered outputs
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cwl_q, cwl_d;
  logic [N-1:0]     adr_q, adr_d;
  logic             read_out_q, read_out_d;
  logic             inference_q, inference_d;

  // Timer interface and helpers
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             row_active_d;
  logic             abort_w;

`ifdef ARRAY_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  array_seq_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state logic; outputs are derived from the next state so that
  // every decoder-facing signal comes straight out of a flop.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    row_d        = row_q;
    widx_d       = widx_q;
    tmr_load     = 1'b0;
    tmr_val      = SETUP_LOAD;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          row_d  = cmd_adr;
          widx_d = '0;
          case (op_e'(cmd_op))
            OP_ROW, OP_INFER: begin
              state_d  = ST_SETUP;
              tmr_load = 1'b1;
              tmr_val  = SETUP_LOAD;
            end
            OP_CLEAR: state_d = ST_CLEAR;
            default: begin
              state_d = ST_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // INFER walks the word index up to its last value without wrapping
        if (op_q == OP_INFER && widx_q != WORD_LAST) begin
          widx_d   = widx_q + 1'b1;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort only matters while a row is being driven
    if (abort_w && (state_q == ST_SETUP || state_q == ST_PULSE ||
                    state_q == ST_HOLD)) begin
      state_d  = ST_DONE;
      err_d    = 1'b1;
      tmr_load = 1'b0;
    end

    row_active_d = (state_d == ST_SETUP) || (state_d == ST_PULSE) ||
                   (state_d == ST_HOLD);
    cmd_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
    cwl_d        = (state_d == ST_PULSE);
    read_out_d   = (state_d == ST_CLEAR);
    inference_d  = row_active_d && (op_d == OP_INFER);
    adr_d        = '0;
    if (row_active_d) begin
      adr_d = (op_d == OP_INFER) ? {row_d[N-1 -: Narray], widx_d} : row_d;
    end
  end

  // Single state/output register bank with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ROW;
      row_q       <= '0;
      widx_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cwl_q       <= 1'b0;
      adr_q       <= '0;
      read_out_q  <= 1'b0;
      inference_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      row_q       <= row_d;
      widx_q      <= widx_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cwl_q       <= cwl_d;
      adr_q       <= adr_d;
      read_out_q  <= read_out_d;
      inference_q <= inference_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign CWL          = cwl_q;
  assign adr_full_row = adr_q;
  assign read_out     = read_out_q;
  assign inference    = inference_q;

endmodule
